trigger_output_capture: RTL and testbench

Snapshot buffer downstream of the 8-channel trigger chain wrapper in the `aclk` domain. It records the per-channel 40-bit trigger-chain output beats into a circular RAM while armed. On a trigger it keeps recording for a programmable number of post-trigger beats, then freezes. Software-side logic reads the frozen record back one channel-beat at a time for filter/AGC debug.

---
 rtl/trigger_output_capture.sv | 124 ++++++++++++
 tb/tb_trigger_output_capture.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_output_capture.sv
// Snapshot buffer for the 8-channel trigger-chain outputs: records into a circular
// RAM while armed, freezes P beats after a trigger, then serves channel-beat reads.
module trigger_output_capture #(
  parameter int DEPTH_LOG2 = 10,
  parameter int NCHAN      = 8,
  parameter int BEAT_WIDTH = 40
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [NCHAN-1:0][BEAT_WIDTH-1:0]      dat_i,
  input  logic                                  arm_i,
  input  logic                                  abort_i,
  input  logic                                  trig_i,
  input  logic [DEPTH_LOG2-1:0]                 post_beats_i,
  output logic [1:0]                            state_o,
  output logic                                  done_o,
  output logic [DEPTH_LOG2-1:0]                 trig_beat_o,
  input  logic                                  rd_en_i,
  input  logic [DEPTH_LOG2+2:0]                 rd_addr_i,
  output logic [BEAT_WIDTH-1:0]                 rd_dat_o,
  output logic                                  rd_valid_o
);

  localparam int DEPTH = 2**DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;

  state_t                  state;
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [DEPTH_LOG2-1:0]   pre_cnt;
  logic [DEPTH_LOG2-1:0]   post_cnt;
  logic [DEPTH_LOG2-1:0]   p_lat;
  logic [DEPTH_LOG2-1:0]   p_new;
  logic [DEPTH_LOG2-1:0]   pre_lim;
  logic                    wr_en;

  logic [NCHAN-1:0][BEAT_WIDTH-1:0] mem [DEPTH];
  logic [NCHAN-1:0][BEAT_WIDTH-1:0] rd_word;
  logic [2:0]              rd_chan;
  logic [2:1]              vld_pipe;
  logic                    rd_req;
  logic [DEPTH_LOG2-1:0]   rd_phys;

  assign p_new   = (post_beats_i == '0) ? DEPTH_LOG2'(1) : post_beats_i;
  // DEPTH - P in DEPTH_LOG2 bits: P is never 0, so the modular negate is exact.
  assign pre_lim = '0 - p_lat;
  assign wr_en   = (state == ARMED) || (state == POST);
  assign state_o = state;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      done_o      <= 1'b0;
      trig_beat_o <= '0;
      wr_ptr      <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      p_lat       <= DEPTH_LOG2'(1);
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (abort_i) begin
        state  <= IDLE;
        done_o <= 1'b0;
      end else begin
        case (state)
          IDLE, DONE: if (arm_i) begin
            state   <= ARMED;
            done_o  <= 1'b0;
            wr_ptr  <= '0;
            pre_cnt <= '0;
            p_lat   <= p_new;
          end
          ARMED: begin
            if (pre_cnt != pre_lim) pre_cnt <= pre_cnt + 1'b1;
            // The trigger edge writes post beat 1, so only P-1 beats remain.
            if (trig_i && (pre_cnt == pre_lim)) begin
              post_cnt <= p_lat - 1'b1;
              if (p_lat == DEPTH_LOG2'(1)) begin
                state       <= DONE;
                done_o      <= 1'b1;
                trig_beat_o <= pre_lim;
              end else begin
                state <= POST;
              end
            end
          end
          POST: begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == DEPTH_LOG2'(1)) begin
              state       <= DONE;
              done_o      <= 1'b1;
              trig_beat_o <= pre_lim;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // In DONE wr_ptr is the oldest beat, so logical addresses are offsets from it.
  assign rd_req  = rd_en_i && (state == DONE);
  assign rd_phys = wr_ptr + rd_addr_i[DEPTH_LOG2+2:3];

  always_ff @(posedge aclk) begin
    if (wr_en)  mem[wr_ptr] <= dat_i;
    if (rd_req) rd_word     <= mem[rd_phys];
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_pipe <= '0;
      rd_chan  <= '0;
      rd_dat_o <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], rd_req};
      if (rd_req)      rd_chan  <= rd_addr_i[2:0];
      if (vld_pipe[1]) rd_dat_o <= rd_word[rd_chan];
    end
  end

  assign rd_valid_o = vld_pipe[2];

endmodule

// File: tb/tb_trigger_output_capture.sv
// Directed bench for trigger_output_capture at DEPTH=16: capture timing, trigger
// gating, wrap-around readback, abort priority and asynchronous reset.
module tb_trigger_output_capture;

  localparam int DL = 4;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [7:0][39:0] dat_i;
  logic             arm_i = 1'b0, abort_i = 1'b0, trig_i = 1'b0;
  logic [DL-1:0]    post_beats_i = '0;
  logic [1:0]       state_o;
  logic             done_o;
  logic [DL-1:0]    trig_beat_o;
  logic             rd_en_i = 1'b0;
  logic [DL+2:0]    rd_addr_i = '0;
  logic [39:0]      rd_dat_o;
  logic             rd_valid_o;

  logic [7:0]       cyc = 8'd0;
  logic [7:0]       trig_cyc;
  int               n_cmp = 0;
  int               n_bad = 0;

  typedef struct {
    logic [DL+2:0] addr;
    logic [39:0]   exp;
  } rd_vec_t;
  rd_vec_t tbl [16];

  trigger_output_capture #(.DEPTH_LOG2(DL), .NCHAN(8), .BEAT_WIDTH(40)) dut (
    .aclk(aclk), .aresetn(aresetn), .dat_i(dat_i), .arm_i(arm_i), .abort_i(abort_i),
    .trig_i(trig_i), .post_beats_i(post_beats_i), .state_o(state_o), .done_o(done_o),
    .trig_beat_o(trig_beat_o), .rd_en_i(rd_en_i), .rd_addr_i(rd_addr_i),
    .rd_dat_o(rd_dat_o), .rd_valid_o(rd_valid_o)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 8'd1;

  always_comb begin
    for (int c = 0; c < 8; c++) dat_i[c] = {3'(c), 29'd0, cyc};
  end

  function automatic logic [39:0] expd(input int c, input logic [7:0] v);
    return {3'(c), 29'd0, v};
  endfunction

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic arm(input logic [DL-1:0] pb);
    arm_i = 1'b1; post_beats_i = pb;
    step();
    arm_i = 1'b0;
  endtask

  task automatic trigger();
    trig_i = 1'b1; trig_cyc = cyc;
    step();
    trig_i = 1'b0;
  endtask

  task automatic do_read(input string nm, input logic [DL+2:0] addr, input logic [39:0] exp);
    rd_en_i = 1'b1; rd_addr_i = addr;
    step();
    rd_en_i = 1'b0;
    chk({nm, "_lat1"}, 64'(rd_valid_o), 64'd0);
    step();
    chk({nm, "_valid"}, 64'(rd_valid_o), 64'd1);
    chk({nm, "_data"}, 64'(rd_dat_o), 64'(exp));
  endtask

  // Logical beat b of a record whose trigger sits at logical 'pre' holds trig_cyc + b - pre.
  task automatic run_table(input string nm, input int pre);
    for (int b = 0; b < 16; b++) begin
      tbl[b].addr = {4'(b), 3'(b % 8)};
      tbl[b].exp  = expd(b % 8, trig_cyc + 8'(b) - 8'(pre));
    end
    for (int i = 0; i < 16; i++) do_read($sformatf("%s_b%0d", nm, i), tbl[i].addr, tbl[i].exp);
  endtask

  initial begin
    #3;
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_valid", 64'(rd_valid_o), 64'd0);
    chk("rst_rdat", 64'(rd_dat_o), 64'd0);
    #4 aresetn = 1'b1;
    step(2);

    // 1: normal capture, P=4
    arm(4'd4);
    chk("t1_armed", 64'(state_o), 64'd1);
    step(12);
    trigger();
    chk("t1_post", 64'(state_o), 64'd2);
    step(2);
    chk("t1_post_k2", 64'(state_o), 64'd2);
    step();
    chk("t1_done", 64'(state_o), 64'd3);
    chk("t1_done_o", 64'(done_o), 64'd1);
    chk("t1_trig_beat", 64'(trig_beat_o), 64'd12);
    run_table("t1", 12);
    do_read("t1_ch7", {4'd12, 3'd7}, expd(7, trig_cyc));

    // 2: early trigger dropped, later one accepted
    arm(4'd4);
    step(4);
    trigger();
    chk("t2_early_drop", 64'(state_o), 64'd1);
    step(7);
    trigger();
    chk("t2_post", 64'(state_o), 64'd2);
    step(3);
    chk("t2_done", 64'(state_o), 64'd3);
    do_read("t2_trig", {4'd12, 3'd2}, expd(2, trig_cyc));
    do_read("t2_oldest", {4'd0, 3'd5}, expd(5, trig_cyc - 8'd12));

    // 3: post_beats=0 behaves as P=1
    arm(4'd0);
    step(15);
    trigger();
    chk("t3_done", 64'(state_o), 64'd3);
    chk("t3_done_o", 64'(done_o), 64'd1);
    chk("t3_trig_beat", 64'(trig_beat_o), 64'd15);
    do_read("t3_trig", {4'd15, 3'd3}, expd(3, trig_cyc));
    do_read("t3_oldest", {4'd0, 3'd0}, expd(0, trig_cyc - 8'd15));

    // 4: wrap-around, P=8, trigger long after arm (oldest lands at physical 2)
    arm(4'd8);
    step(42);
    chk("t4_still_armed", 64'(state_o), 64'd1);
    trigger();
    step(6);
    chk("t4_post", 64'(state_o), 64'd2);
    step();
    chk("t4_done", 64'(state_o), 64'd3);
    chk("t4_trig_beat", 64'(trig_beat_o), 64'd8);
    run_table("t4", 8);
    // a read issued alongside a re-arm still completes
    rd_en_i = 1'b1; rd_addr_i = {4'd8, 3'd6}; arm_i = 1'b1; post_beats_i = 4'd4;
    step();
    rd_en_i = 1'b0; arm_i = 1'b0;
    chk("t4_rearm_state", 64'(state_o), 64'd1);
    step();
    chk("t4_rearm_rd_valid", 64'(rd_valid_o), 64'd1);
    chk("t4_rearm_rd_data", 64'(rd_dat_o), 64'(expd(6, trig_cyc)));
    abort_i = 1'b1; step(); abort_i = 1'b0;

    // 5: abort in POST; abort beats arm in DONE; reads blocked afterwards
    arm(4'd4);
    step(12);
    trigger();
    chk("t5_post", 64'(state_o), 64'd2);
    abort_i = 1'b1; step(); abort_i = 1'b0;
    chk("t5_abort_post", 64'(state_o), 64'd0);
    step(4);
    chk("t5_stays_idle", 64'(state_o), 64'd0);
    arm(4'd0);
    step(15);
    trigger();
    chk("t5_done", 64'(state_o), 64'd3);
    abort_i = 1'b1; arm_i = 1'b1; step(); abort_i = 1'b0; arm_i = 1'b0;
    chk("t5_abort_prio", 64'(state_o), 64'd0);
    chk("t5_done_o", 64'(done_o), 64'd0);
    rd_en_i = 1'b1; rd_addr_i = '0;
    step(2);
    rd_en_i = 1'b0;
    chk("t5_no_rd_valid", 64'(rd_valid_o), 64'd0);
    step();
    chk("t5_no_rd_valid2", 64'(rd_valid_o), 64'd0);

    // 6: reset in the middle of POST
    arm(4'd8);
    step(8);
    trigger();
    chk("t6_post", 64'(state_o), 64'd2);
    #2 aresetn = 1'b0;
    #1;
    chk("t6_rst_state", 64'(state_o), 64'd0);
    chk("t6_rst_done", 64'(done_o), 64'd0);
    chk("t6_rst_trig_beat", 64'(trig_beat_o), 64'd0);
    chk("t6_rst_rdat", 64'(rd_dat_o), 64'd0);
    chk("t6_rst_valid", 64'(rd_valid_o), 64'd0);
    step();
    #2 aresetn = 1'b1;
    step();
    chk("t6_idle", 64'(state_o), 64'd0);
    trigger();
    chk("t6_trig_ignored", 64'(state_o), 64'd0);
    step(2);
    chk("t6_trig_ignored2", 64'(state_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
